// File: rtl/cowcat_pkg.sv
// Shared definitions for the load/store access path: mem_ctl encodings, FSM states
// and store lane helpers. MEM_MISALIGN_CHECK_EN adds the MISAL state.
package cowcat_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam int ACK_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
`ifdef MEM_MISALIGN_CHECK_EN
        , S_MISAL = 2'd3
`endif
    } state_t;

    function automatic logic [3:0] store_be(input logic [2:0] ctl, input logic [1:0] off);
        case (ctl)
            MEM_B:   return 4'b0001 << off;
            MEM_H:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate the operand so every enabled lane carries the data.
    function automatic logic [31:0] store_lanes(input logic [2:0] ctl, input logic [31:0] data);
        case (ctl)
            MEM_B:   return {4{data[7:0]}};
            MEM_H:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] ctl, input logic [1:0] off);
        if (ctl == MEM_H || ctl == MEM_HU)
            return off[0];
        else if (ctl == MEM_W)
            return off != 2'b00;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/load_trim.sv
// Combinational load extraction: picks the byte/halfword addressed by addr_lo and
// sign- or zero-extends it according to mem_ctl.
module load_trim
    import cowcat_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_ctl,
    output logic [31:0] trim_word
);

    logic        [7:0]  byte_sel;
    logic        [15:0] half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    assign byte_s = byte_sel;
    assign half_s = half_sel;

    always_comb begin
        trim_word = rdata;
        case (mem_ctl)
            MEM_B:   trim_word = 32'(byte_s);
            MEM_H:   trim_word = 32'(half_s);
            MEM_BU:  trim_word = {24'd0, byte_sel};
            MEM_HU:  trim_word = {16'd0, half_sel};
            default: trim_word = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store sequencer: one memory request per start pulse, ack timeout, load trim.
// Define MEM_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses without a request.
module mem_access
    import cowcat_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  mem_ctl,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] trim_out,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        misalign
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       ctl_q;
    logic [1:0]       off_q;
    logic             store_q;
    logic [31:0]      trim_word;

    load_trim u_load_trim (
        .rdata     (dmem_rdata),
        .addr_lo   (off_q),
        .mem_ctl   (ctl_q),
        .trim_word (trim_word)
    );

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q;
    logic misal_hit;
    assign misal_hit = is_misaligned(mem_ctl, addr[1:0]);
    assign misalign  = misalign_q;
`else
    assign misalign  = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            ctl_q      <= '0;
            off_q      <= '0;
            store_q    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            trim_out   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ctl_q      <= mem_ctl;
                        off_q      <= addr[1:0];
                        store_q    <= is_store;
                        wait_cnt   <= '0;
                        err        <= 1'b0;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= is_store ? store_be(mem_ctl, addr[1:0]) : 4'b1111;
                        dmem_wdata <= store_lanes(mem_ctl, store_data);
`ifdef MEM_MISALIGN_CHECK_EN
                        misalign_q <= 1'b0;
                        if (misal_hit) begin
                            state <= S_MISAL;
                        end else begin
                            state    <= S_REQ;
                            dmem_req <= 1'b1;
                            dmem_we  <= is_store;
                        end
`else
                        state    <= S_REQ;
                        dmem_req <= 1'b1;
                        dmem_we  <= is_store;
`endif
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        state    <= S_DONE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        done     <= 1'b1;
                        if (!store_q)
                            trim_out <= trim_word;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Give up after ACK_TIMEOUT unacknowledged request cycles.
                        state    <= S_DONE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
`ifdef MEM_MISALIGN_CHECK_EN
                S_MISAL: begin
                    state      <= S_DONE;
                    misalign_q <= 1'b1;
                    done       <= 1'b1;
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a scoreboard of expected completions.
module tb_mem_access;
    import cowcat_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  mem_ctl;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] trim_out;
    logic        done;
    logic        busy;
    logic        err;
    logic        misalign;

    mem_access #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .mem_ctl    (mem_ctl),
        .addr       (addr),
        .store_data (store_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .trim_out   (trim_out),
        .done       (done),
        .busy       (busy),
        .err        (err),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int          id;
        int          cyc;
        logic [31:0] trim;
        logic        err;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no access outstanding", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("t%0d_done_cycle", e.id), cyc, e.cyc);
                chk($sformatf("t%0d_trim_out", e.id), trim_out, e.trim);
                chk($sformatf("t%0d_err", e.id), err, e.err);
                chk($sformatf("t%0d_misalign", e.id), misalign, e.mis);
            end
        end
    end

    task automatic check_reset_state(input string p);
        chk({p, "_dmem_req"}, dmem_req, 0);
        chk({p, "_dmem_we"}, dmem_we, 0);
        chk({p, "_dmem_be"}, dmem_be, 0);
        chk({p, "_dmem_addr"}, dmem_addr, 0);
        chk({p, "_dmem_wdata"}, dmem_wdata, 0);
        chk({p, "_trim_out"}, trim_out, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_misalign"}, misalign, 0);
    endtask

    // waits < 0 means never ack; glitch pulses start again while the access is in flight.
    task automatic access(input int id, input bit st, input logic [2:0] ctl,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_trim, input bit exp_err, input bit exp_mis,
                          input bit glitch);
        exp_t e;
        int   k;
        int   b;
        int   lat;
        int   req_cycles;
        if (exp_mis) begin
            lat = 2;
            req_cycles = 0;
        end else if (waits < 0) begin
            lat = TO + 1;
            req_cycles = TO;
        end else begin
            lat = waits + 2;
            req_cycles = waits + 1;
        end
        @(negedge clk);
        start = 1'b1; is_store = st; mem_ctl = ctl; addr = a; store_data = sd;
        e.id = id; e.cyc = cyc + lat; e.trim = exp_trim; e.err = exp_err; e.mis = exp_mis;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("t%0d_busy", id), busy, 1);
        k = 0;
        while (dmem_req === 1'b1 && k < 300) begin
            chk($sformatf("t%0d_dmem_addr", id), dmem_addr, {a[31:2], 2'b00});
            chk($sformatf("t%0d_dmem_be", id), dmem_be, exp_be);
            chk($sformatf("t%0d_dmem_we", id), dmem_we, st);
            if (st) chk($sformatf("t%0d_dmem_wdata", id), dmem_wdata, exp_wd);
            if (glitch && k == 0) begin
                start = 1'b1; is_store = 1'b1; mem_ctl = MEM_B; addr = 32'h0000_0F01;
                store_data = 32'h5555_5555;
            end else begin
                start = 1'b0;
            end
            if (k == waits) begin
                dmem_ack = 1'b1;
                dmem_rdata = rd;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = 32'hFFFF_FFFF;
            start = 1'b0;
            k++;
        end
        chk($sformatf("t%0d_req_cycles", id), k, req_cycles);
        b = 0;
        while (busy === 1'b1 && b < 10) begin
            @(negedge clk);
            b++;
        end
        chk($sformatf("t%0d_idle_after", id), busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; mem_ctl = MEM_W; addr = '0;
        store_data = '0; dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        //      id st ctl     addr          store         rdata         waits be       wdata         trim          err mis gl
        access(1,  0, MEM_B,  32'h0000_0103, 32'h0,        32'h80FF_1234, 2,  4'b1111, 32'h0,        32'hFFFF_FF80, 0, 0, 0);
        access(2,  0, MEM_HU, 32'h0000_0102, 32'h0,        32'h9ABC_5678, 0,  4'b1111, 32'h0,        32'h0000_9ABC, 0, 0, 0);
        access(3,  1, MEM_B,  32'h0000_0201, 32'h1122_3344, 32'hFFFF_FFFF, 0, 4'b0010, 32'h4444_4444, 32'h0000_9ABC, 0, 0, 0);
        access(4,  1, MEM_H,  32'h0000_0206, 32'hAABB_CCDD, 32'h0000_0000, 1, 4'b1100, 32'hCCDD_CCDD, 32'h0000_9ABC, 0, 0, 0);
        access(5,  0, MEM_H,  32'h0000_0100, 32'h0,        32'h1234_8001, 0,  4'b1111, 32'h0,        32'hFFFF_8001, 0, 0, 0);
        access(6,  0, MEM_BU, 32'h0000_0101, 32'h0,        32'h0000_F700, 0,  4'b1111, 32'h0,        32'h0000_00F7, 0, 0, 0);
        access(7,  0, MEM_B,  32'h0000_0100, 32'h0,        32'h0000_007F, 1,  4'b1111, 32'h0,        32'h0000_007F, 0, 0, 0);
        access(8,  0, MEM_W,  32'h0000_0108, 32'h0,        32'hCAFE_BABE, 3,  4'b1111, 32'h0,        32'hCAFE_BABE, 0, 0, 1);
        access(9,  0, 3'b011, 32'h0000_010C, 32'h0,        32'h1357_9BDF, 0,  4'b1111, 32'h0,        32'h1357_9BDF, 0, 0, 0);
        access(10, 0, MEM_W,  32'h0000_0110, 32'h0,        32'h0000_0000, -1, 4'b1111, 32'h0,        32'h1357_9BDF, 1, 0, 0);
        chk("t10_err_held_in_idle", err, 1);
        access(11, 0, MEM_B,  32'h0000_0102, 32'h0,        32'h00AB_0000, 0,  4'b1111, 32'h0,        32'hFFFF_FFAB, 0, 0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        access(12, 1, MEM_W,  32'h0000_0302, 32'h0102_0304, 32'h0,        0,  4'b1111, 32'h0102_0304, 32'hFFFF_FFAB, 0, 1, 0);
`else
        access(12, 1, MEM_W,  32'h0000_0302, 32'h0102_0304, 32'h0,        0,  4'b1111, 32'h0102_0304, 32'hFFFF_FFAB, 0, 0, 0);
`endif

        // A stray ack while idle must not start anything.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
        chk("stray_ack_busy", busy, 0);
        chk("stray_ack_trim", trim_out, 32'hFFFF_FFAB);

        // Reset in the second REQ cycle, then a late ack.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; mem_ctl = MEM_W; addr = 32'h0000_0400;
        @(negedge clk);
        start = 1'b0;
        chk("rstreq_first_req", dmem_req, 1);
        @(negedge clk);
        chk("rstreq_second_req", dmem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstreq_req_dropped", dmem_req, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
        check_reset_state("rstreq");
        repeat (2) @(negedge clk);
        chk("rstreq_still_idle", busy, 0);

        access(13, 0, MEM_HU, 32'h0000_0106, 32'h0,        32'h8001_0000, 0,  4'b1111, 32'h0,        32'h0000_8001, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for dmem_ack.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that begins an access.
REQ-006 is_store  in  1  1 = store, 0 = load.
REQ-007 mem_ctl  in  3  funct3 encoding: 000 byte, 001 half, 010 word; 100 byte-unsigned and 101 half-unsigned (loads only).
REQ-008 addr  in  32  effective address, taken from the ALU output.
REQ-009 store_data  in  32  store operand, taken from rs2.
REQ-010 dmem_req / dmem_we  out  1 / 1  memory request / write strobe.
REQ-011 dmem_addr  out  32  word-aligned address: addr with bits [1:0] forced to 0.
REQ-012 dmem_wdata / dmem_be  out  32 / 4  lane-replicated write data / byte enables.
REQ-013 dmem_ack / dmem_rdata  in  1 / 32  memory completion / read word.
REQ-014 trim_out  out  32  trimmed load result; this is the trim_forward source for the ALU operand mux.
REQ-015 done / busy / err / misalign  out  1 each  completion pulse / access in flight / ack timeout / misaligned-access flag.

Function
REQ-016 FSM states SHALL be IDLE, REQ, DONE (plus MISAL when MEM_MISALIGN_CHECK_EN is defined); busy SHALL be 1 in every state except IDLE.
REQ-017 When start=1 in IDLE, the block SHALL latch addr, store_data, mem_ctl and is_store and go to REQ; start SHALL be ignored while busy=1.
REQ-018 In REQ, dmem_req SHALL be 1, and dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL stay stable until the cycle in which dmem_ack=1.
REQ-019 dmem_ack=1 in REQ SHALL cause a transition to DONE; dmem_ack sampled outside REQ SHALL be ignored.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE. Minimum latency: start at cycle N, dmem_req at N+1, ack at N+1, done at N+2.
REQ-021 Byte enables and write data:
  - SB: dmem_be = 4'b0001 << addr[1:0]; byte replicated to all lanes.
  - SH: dmem_be = 0011 if addr[1]=0, else 1100; halfword replicated.
  - SW, and any other encoding: dmem_be = 1111.
  - Loads: dmem_be = 1111, dmem_we = 0.
REQ-022 Load trim: the byte/halfword SHALL be selected by addr[1:0] / addr[1], sign-extended for 000/001, zero-extended for 100/101, with the full word for all other encodings. The result is registered into trim_out on the ack cycle.
REQ-023 trim_out SHALL hold its value until the next load completes; stores and timeouts SHALL NOT change it.
REQ-024 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack. When it reaches ACK_TIMEOUT, the block SHALL deassert dmem_req, set err=1 and go to DONE.
REQ-025 err and misalign SHALL be valid in the done cycle and clear on the next accepted start.

Reset
REQ-026 On rst, the block SHALL go to IDLE and drive dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, trim_out=0, done=0, busy=0, err=0, misalign=0, and clear the counter.
REQ-027 rst SHALL take effect during an access in any state; dmem_req SHALL be 0 in the cycle after the reset edge, and a late ack SHALL be ignored.

Configuration
REQ-028 Macro MEM_MISALIGN_CHECK_EN defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL go IDLE->MISAL->DONE. No dmem_req is issued, misalign=1 and trim_out is unchanged.
REQ-029 MEM_MISALIGN_CHECK_EN undefined: misalign SHALL be tied to 0, and the ignored low address bits SHALL follow REQ-021/REQ-022.

Structure
REQ-030 A shared package cowcat_pkg SHALL hold the mem_ctl encodings, the FSM state type and the ACK_TIMEOUT default.
REQ-031 Load extraction and extension SHALL be a combinational sub-module load_trim (inputs rdata, addr[1:0], mem_ctl; output 32-bit word).

Verification
REQ-032 LB at addr 0x103 with rdata 0x80FF_1234 and ack after 2 wait cycles -> trim_out 0xFFFF_FF80, done pulse at cycle N+4.
REQ-033 LHU at addr 0x102 with rdata 0x9ABC_5678 and same-cycle ack -> trim_out 0x0000_9ABC, done at N+2.
REQ-034 SB data 0x11223344 at addr 0x201 -> dmem_be 0010, dmem_wdata 0x44444444, dmem_addr 0x200, trim_out unchanged.
REQ-035 LW with ACK_TIMEOUT=4 and no ack -> dmem_req drops after 4 REQ cycles, err=1 with done, trim_out unchanged.
REQ-036 With MEM_MISALIGN_CHECK_EN: SW at 0x302 -> no dmem_req, misalign=1 with done at N+2.
REQ-037 rst asserted in the second REQ cycle, then ack one cycle later -> IDLE, busy=0, no done pulse, all outputs at reset values.
